load_state_machine: RTL

//  Read-side counterpart of the memory controller's store sequencer: accepts a load request,

---
 rtl/mem_ctrl_pkg.sv | 22 ++
 rtl/load_state_machine_if.sv | 30 +++
 rtl/load_state_machine.sv | 79 +++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared memory-controller types: sequencer state encodings and bus width defaults.
// Imported by the load/store sequencers and the arbiter.
package mem_ctrl_pkg;

  localparam int MC_ADDR_W = 16;
  localparam int MC_DATA_W = 16;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_READ = 2'd1,
    LD_DONE = 2'd2,
    LD_ERR  = 2'd3
  } ld_state_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERR   = 2'd3
  } st_state_e;

endpackage

// File: rtl/load_state_machine_if.sv
// Load sequencer bus: core-side request/write-back and data-memory read port.
// slave = sequencer side, master = requester/memory side.
interface load_state_machine_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              loadReq;
  logic [ADDR_W-1:0] addrIn;
  logic              memReady;
  logic [DATA_W-1:0] memDataIn;
  logic [ADDR_W-1:0] memAddr;
  logic              memRead;
  logic [DATA_W-1:0] loadData;
  logic              lwEnable;
  logic              loadEnd;
  logic              busy;
  logic              loadErr;

  modport slave (
    input  loadReq, addrIn, memReady, memDataIn,
    output memAddr, memRead, loadData,
    output lwEnable, loadEnd, busy, loadErr
  );

  modport master (
    output loadReq, addrIn, memReady, memDataIn,
    input  memAddr, memRead, loadData,
    input  lwEnable, loadEnd, busy, loadErr
  );
endinterface

// File: rtl/load_state_machine.sv
// Load sequencer: latch address, strobe memory read until ready, capture word, pulse write-back.
// Optional READ timeout abort enabled by defining LOAD_TIMEOUT_EN.
module load_state_machine
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = MC_ADDR_W,
  parameter int DATA_W  = MC_DATA_W,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rstn,
  load_state_machine_if.slave bus
);

  ld_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

`ifdef LOAD_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  logic [TW-1:0] timer_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= LD_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef LOAD_TIMEOUT_EN
      timer_q <= '0;
`endif
    end else begin
      case (state_q)
        LD_IDLE: begin
          if (bus.loadReq) begin
            addr_q  <= bus.addrIn;
            state_q <= LD_READ;
`ifdef LOAD_TIMEOUT_EN
            timer_q <= '0;
`endif
          end
        end
        LD_READ: begin
          // ready in the expiry cycle still captures
          if (bus.memReady) begin
            data_q  <= bus.memDataIn;
            state_q <= LD_DONE;
          end
`ifdef LOAD_TIMEOUT_EN
          else if (timer_q == TMAX) begin
            state_q <= LD_ERR;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
`endif
        end
        LD_DONE: state_q <= LD_IDLE;
        default: state_q <= LD_IDLE;
      endcase
    end
  end

  assign bus.memAddr  = addr_q;
  assign bus.loadData = data_q;
  assign bus.memRead  = (state_q == LD_READ);
  assign bus.lwEnable = (state_q == LD_DONE);
  assign bus.loadEnd  = (state_q == LD_DONE);
  assign bus.busy     = (state_q != LD_IDLE);
`ifdef LOAD_TIMEOUT_EN
  assign bus.loadErr  = (state_q == LD_ERR);
`else
  assign bus.loadErr  = 1'b0;
`endif

endmodule
